s_term_loopback_bist: RTL



---
 rtl/s_term_loopback_bist.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/s_term_loopback_bist.sv
// rtl/s_term_loopback_bist.sv - south terminal loopback tile with PRBS self-test
// Optional first-error capture ports are enabled by defining S_TERM_FIRST_ERR_EN.

module s_term_loopback_bist #(
  parameter int unsigned WORDS = 256,
  parameter logic [51:0] SEED  = 52'h0_0000_0000_0001
) (
  input  logic        UserCLK,
  input  logic        RESET,
  input  logic [3:0]  S1END,
  input  logic [7:0]  S2MID,
  input  logic [7:0]  S2END,
  input  logic [15:0] SS4END,
  input  logic [15:0] S4END,
  output logic [3:0]  N1BEG,
  output logic [7:0]  N2BEG,
  output logic [7:0]  N2BEGb,
  output logic [15:0] NN4BEG,
  output logic [15:0] N4BEG,
  input  logic        TEST_EN,
  input  logic        TEST_START,
  input  logic [2:0]  TEST_LAT,
  output logic        TEST_BUSY,
  output logic        TEST_DONE,
  output logic        TEST_PASS,
  output logic [15:0] ERR_COUNT
`ifdef S_TERM_FIRST_ERR_EN
  ,
  output logic [15:0] FIRST_ERR_IDX,
  output logic [51:0] FIRST_ERR_SYN
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_DRAIN, ST_DONE} state_t;

  localparam logic [15:0] LP_LAST = 16'(WORDS - 1);

  state_t      r_state, w_next;
  logic [51:0] r_tx, r_rx;
  logic [51:0] r_exp [8];
  logic [7:0]  r_vld;
  logic [15:0] r_cnt, r_err;
  logic [2:0]  r_lat;
  logic        r_pass;

  logic [51:0] w_rx, w_lb;
  logic [15:0] w_err_nxt;
  logic        w_busy, w_start, w_abort, w_cmp, w_hit;

  function automatic logic [51:0] f_lfsr(input logic [51:0] s);
    return {s[50:0], s[51] ^ s[48]};
  endfunction

  assign w_rx      = {S1END, S2MID, S2END, SS4END, S4END};
  assign w_busy    = (r_state == ST_LAUNCH) || (r_state == ST_DRAIN);
  assign w_start   = (r_state == ST_IDLE) && TEST_EN && TEST_START;
  assign w_abort   = w_busy && !TEST_EN;
  assign w_cmp     = w_busy && TEST_EN && r_vld[r_lat];
  assign w_hit     = w_cmp && (r_rx != r_exp[r_lat]);
  assign w_err_nxt = (w_hit && (r_err != 16'hFFFF)) ? r_err + 16'd1 : r_err;

  // Turnaround reverses bit order within each wire group.
  for (genvar i = 0; i < 4; i++) begin : g_n1
    assign w_lb[48+i] = S1END[3-i];
  end
  for (genvar i = 0; i < 8; i++) begin : g_n2
    assign w_lb[40+i] = S2MID[7-i];
    assign w_lb[32+i] = S2END[7-i];
  end
  for (genvar i = 0; i < 16; i++) begin : g_n4
    assign w_lb[16+i] = SS4END[15-i];
    assign w_lb[i]    = S4END[15-i];
  end

  assign {N1BEG, N2BEG, N2BEGb, NN4BEG, N4BEG} = TEST_EN ? r_tx : w_lb;

  always_ff @(posedge UserCLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_next = ST_LAUNCH;
      ST_LAUNCH: if (!TEST_EN) w_next = ST_IDLE;
                 else if (r_cnt == LP_LAST) w_next = ST_DRAIN;
      ST_DRAIN:  if (!TEST_EN) w_next = ST_IDLE;
                 else if (r_cnt[2:0] == r_lat) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (RESET) begin
      r_tx   <= '0;
      r_rx   <= '0;
      r_vld  <= '0;
      r_cnt  <= '0;
      r_err  <= '0;
      r_lat  <= '0;
      r_pass <= 1'b0;
    end else begin
      r_rx <= w_rx;
      if (w_start) begin
        r_tx  <= SEED;
        r_cnt <= '0;
        r_lat <= TEST_LAT;
        r_err <= '0;
        r_vld <= '0;
      end else begin
        r_err <= w_err_nxt;
        if (w_abort)      r_vld <= '0;
        else if (TEST_EN) r_vld <= {r_vld[6:0], r_state == ST_LAUNCH};
        if (r_state == ST_LAUNCH && w_next == ST_LAUNCH) begin
          r_tx  <= f_lfsr(r_tx);
          r_cnt <= r_cnt + 16'd1;
        end else if (r_state == ST_DRAIN && w_next == ST_DRAIN) begin
          r_tx  <= '0;
          r_cnt <= r_cnt + 16'd1;
        end else begin
          r_tx  <= '0;
          r_cnt <= '0;
        end
        // Verdict uses the count including the final compare on this edge.
        if (r_state == ST_DRAIN && w_next == ST_DONE) r_pass <= (w_err_nxt == 16'd0);
      end
    end
  end

  always_ff @(posedge UserCLK) begin
    if (TEST_EN) begin
      r_exp[0] <= r_tx;
      for (int i = 1; i < 8; i++) r_exp[i] <= r_exp[i-1];
    end
  end

  assign TEST_BUSY = w_busy;
  assign TEST_DONE = (r_state == ST_DONE);
  assign TEST_PASS = r_pass;
  assign ERR_COUNT = r_err;

`ifdef S_TERM_FIRST_ERR_EN
  logic [15:0] r_cmp_idx, r_fidx;
  logic [51:0] r_fsyn;

  // Words are compared in launch order, so a compare counter gives the word index.
  always_ff @(posedge UserCLK) begin
    if (RESET || w_start) begin
      r_cmp_idx <= '0;
      r_fidx    <= 16'hFFFF;
      r_fsyn    <= '0;
    end else begin
      if (w_cmp) r_cmp_idx <= r_cmp_idx + 16'd1;
      if (w_hit && r_fidx == 16'hFFFF) begin
        r_fidx <= r_cmp_idx;
        r_fsyn <= r_rx ^ r_exp[r_lat];
      end
    end
  end

  assign FIRST_ERR_IDX = r_fidx;
  assign FIRST_ERR_SYN = r_fsyn;
`endif

endmodule
